// File: rtl/ro_tile_pkg.sv
// Shared types and constants for the ring-oscillator tile measurement path.
package ro_tile_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COUNT  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int SETTLE_CYCLES = 2;
   localparam int CNT_W_DEF     = 10;
   localparam int WIN_W_DEF     = 12;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; edge_o is a one-cycle pulse per synchronized rising edge.
module ro_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic edge_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q,  dly_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign edge_o = sync_q & ~dly_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Gated edge-count measurement controller: settles the synchronizer, counts
// ring-oscillator edges over a programmable window, then latches the result.
module ro_meas_ctrl
   import ro_tile_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] win_len,
   input  logic             ro_in,
   input  logic             byte_sel,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [CNT_W-1:0] result,
   output logic [7:0]       res_byte
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [1:0]       settle_q, settle_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             ro_edge;

   ro_edge_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(ro_in),
      .edge_o (ro_edge)
   );

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && (win_len != '0)) begin
               win_d    = win_len;
               cnt_d    = '0;
               sat_d    = 1'b0;
               settle_d = 2'(SETTLE_CYCLES - 1);
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (settle_q == 2'd0) begin
               state_d = ST_COUNT;
            end else begin
               settle_d = settle_q - 2'd1;
            end
         end
         ST_COUNT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               if (ro_edge) begin
                  if (cnt_q == CNT_MAX) sat_d = 1'b1;
                  else                  cnt_d = cnt_q + 1'b1;
               end
               // Result is registered on entry to DONE so it is valid with done.
               if (win_q == WIN_W'(1)) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  result_d = cnt_d;
                  ovf_d    = sat_d;
               end else begin
                  win_d = win_q - 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         win_q    <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign result   = result_q;
   assign res_byte = byte_sel ? 8'(result_q >> 8) : result_q[7:0];

endmodule
